// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, operation codes and watchdog default for muldiv_ctrl
package muldiv_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, EXC} state_t;
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int TIMEOUT_CYCLES_DEFAULT = 40;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: control-unit and mult/div-unit handshake bundle around muldiv_ctrl
interface muldiv_if #(parameter int CNT_W = 6);
    logic req, op, ack, mult_init, div_init, mult_stop, div_stop, div_zero;
    logic hilo_sel, high_load, low_load, busy, done, exc_divzero, timeout;
    logic [CNT_W-1:0] cycle_count;
    modport master(
        output req, op, mult_stop, div_stop, div_zero,
        input ack, mult_init, div_init, hilo_sel, high_load, low_load, busy, done, exc_divzero, timeout, cycle_count
    );
    modport slave(
        input req, op, mult_stop, div_stop, div_zero,
        output ack, mult_init, div_init, hilo_sel, high_load, low_load, busy, done, exc_divzero, timeout, cycle_count
    );
endinterface

// File: rtl/muldiv_cycle_counter.sv
// muldiv_cycle_counter: saturating WAIT-cycle counter with clear and threshold compare
module muldiv_cycle_counter #(
    parameter int CNT_W = 6,
    parameter int LIMIT = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + CNT_W'(1);
    assign at_limit = count == CNT_W'(LIMIT);
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one mult/div operation from request to HI/LO load or exception.
// Define MULDIV_TIMEOUT_EN to enable the WAIT watchdog abort.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_W = 6
) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    state_t state, state_n;
    logic clr, inc, at_limit, wd_en, sel_stop, sel_n, div_exc, wd_exc;
`ifdef MULDIV_TIMEOUT_EN
    assign wd_en = 1'b1;
`else
    assign wd_en = 1'b0;
`endif
    assign sel_stop = bus.hilo_sel == OP_DIV ? bus.div_stop : bus.mult_stop;
    assign sel_n = (state == IDLE && bus.req) ? bus.op : bus.hilo_sel;
    muldiv_cycle_counter #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .inc(inc),
        .count(bus.cycle_count),
        .at_limit(at_limit)
    );
    // A stop seen in WAIT freezes the count, so cycle_count reports stop-less WAIT cycles
    always_comb begin
        state_n = state;
        clr = 1'b0;
        inc = 1'b0;
        div_exc = 1'b0;
        wd_exc = 1'b0;
        case (state)
            IDLE: if (bus.req) begin
                clr = 1'b1;
                state_n = START;
            end
            START, WAIT: if (sel_stop) begin
                div_exc = bus.hilo_sel == OP_DIV && bus.div_zero;
                state_n = div_exc ? EXC : WRITE;
            end else if (state == START) begin
                state_n = WAIT;
            end else if (wd_en && at_limit) begin
                wd_exc = 1'b1;
                state_n = EXC;
            end else begin
                inc = 1'b1;
            end
            WRITE, EXC: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            bus.hilo_sel <= 1'b0;
            bus.ack <= 1'b0;
            bus.mult_init <= 1'b0;
            bus.div_init <= 1'b0;
            bus.high_load <= 1'b0;
            bus.low_load <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.exc_divzero <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            state <= state_n;
            bus.hilo_sel <= sel_n;
            bus.ack <= state_n == START;
            bus.mult_init <= state_n == START && sel_n == OP_MULT;
            bus.div_init <= state_n == START && sel_n == OP_DIV;
            bus.high_load <= state_n == WRITE;
            bus.low_load <= state_n == WRITE;
            bus.busy <= state_n != IDLE;
            bus.done <= state_n == WRITE || state_n == EXC;
            bus.exc_divzero <= div_exc;
            bus.timeout <= wd_exc;
        end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized transactions against a per-cycle arithmetic model of muldiv_ctrl
module tb_muldiv_ctrl;
    localparam int TO = 40;
    localparam int CNT_W = 6;
    localparam int CMAX = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    muldiv_if #(.CNT_W(CNT_W)) bus();
    muldiv_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [9:0] outs();
        return {bus.ack, bus.mult_init, bus.div_init, bus.hilo_sel, bus.high_load,
                bus.low_load, bus.busy, bus.done, bus.exc_divzero, bus.timeout};
    endfunction
    // n: WAIT cycles before the selected stop; stop lands on edge n+2 after the req edge
    task automatic run_op(input logic o, input int n, input logic dz, input int hold,
                          input logic at_done, input logic noise);
        int s, c;
        logic eto, edz, ld, sel;
        s = n + 2;
        eto = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        if (n > TO) begin
            s = TO + 2;
            eto = 1'b1;
        end
`endif
        edz = o && dz && !eto;
        ld = !eto && !edz;
        @(negedge clk);
        bus.req = 1'b1;
        bus.op = o;
        for (int k = 0; k <= s + 1; k++) begin
            @(negedge clk);
            c = k - 1;
            if (c < 0) c = 0;
            if (c > s - 2) c = s - 2;
            if (c > CMAX) c = CMAX;
            check($sformatf("outs op=%0d n=%0d k=%0d", o, n, k), {22'd0, outs()},
                  {22'd0, k == 0, k == 0 && !o, k == 0 && o, o, k == s && ld, k == s && ld,
                   k <= s, k == s, k == s && edz, k == s && eto});
            check($sformatf("count op=%0d n=%0d k=%0d", o, n, k), {26'd0, bus.cycle_count}, c);
            bus.req = (k + 1 < hold) || (at_done && k + 1 == s + 1);
            sel = !eto && k + 1 == s;
            bus.mult_stop = o ? (noise && $urandom_range(0, 1) == 1) : sel;
            bus.div_stop = o ? sel : (noise && $urandom_range(0, 1) == 1);
            bus.div_zero = o ? (dz && sel) : (noise && $urandom_range(0, 1) == 1);
        end
        bus.mult_stop = 1'b0;
        bus.div_stop = 1'b0;
        bus.div_zero = 1'b0;
    endtask
    initial begin
        bus.req = 1'b0;
        bus.op = 1'b0;
        bus.mult_stop = 1'b0;
        bus.div_stop = 1'b0;
        bus.div_zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outs", {22'd0, outs()}, 0);
        check("reset count", {26'd0, bus.cycle_count}, 0);
        rst_n = 1'b1;
        run_op(1'b0, 32, 1'b0, 1, 1'b0, 1'b0);
        run_op(1'b1, 5, 1'b1, 1, 1'b0, 1'b0);
        run_op(1'b0, 8, 1'b0, 3, 1'b1, 1'b0);
        run_op(1'b1, 9, 1'b0, 1, 1'b0, 1'b1);
        run_op(1'b1, 0, 1'b0, 2, 1'b1, 1'b1);
        run_op(1'b0, 70, 1'b0, 1, 1'b0, 1'b0);
`ifdef MULDIV_TIMEOUT_EN
        run_op(1'b0, TO, 1'b0, 1, 1'b0, 1'b0);
        run_op(1'b1, 200, 1'b0, 1, 1'b0, 1'b0);
        run_op(1'b1, TO, 1'b1, 1, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 20; i++)
            run_op($urandom_range(0, 1) == 1, $urandom_range(0, 12), $urandom_range(0, 1) == 1,
                   $urandom_range(1, 3), $urandom_range(0, 1) == 1, 1'b1);
        @(negedge clk);
        bus.req = 1'b1;
        bus.op = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        check("busy before reset", {31'd0, bus.busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outs", {22'd0, outs()}, 0);
        check("async reset count", {26'd0, bus.cycle_count}, 0);
        bus.div_stop = 1'b1;
        @(negedge clk);
        check("held reset outs", {22'd0, outs()}, 0);
        bus.div_stop = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("after reset outs", {22'd0, outs()}, 0);
        run_op(1'b1, 3, 1'b0, 1, 1'b0, 1'b0);
        run_op(1'b0, 4, 1'b0, 1, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
